ddr_rx_frame_ctrl: RTL and testbench
====================================

// Module: ddr_rx_frame_ctrl
// PURPOSE
//  Sequencer for the HDR-DDR RX deserializer during a controller read.
//  - Drives rx_en/rx_mode and steps through ACK preamble, data words (2 bytes + parity), CRC preamble, token and CRC.
//  - Pushes received bytes to the read FIFO and reports done/error to the DDR CCC engine.
// PARAMETERS
//  MAX_WORDS       255   upper bound of i_rd_word_cnt; sets the counter width to $clog2(MAX_WORDS+1)
//  TIMEOUT_CYCLES  1024  sys_clk cycles allowed per RX mode before timeout (only with DDR_RX_TIMEOUT_EN)
// PORTS
//  i_sys_clk        in   1   system clock, 50 MHz
//  i_sys_rst        in   1   asynchronous, active-high reset
//  i_rd_start       in   1   1-cycle pulse: start a read frame; sampled only in IDLE
//  i_rd_word_cnt    in   W   number of data words requested (1..MAX_WORDS), sampled with i_rd_start
//  i_abort          in   1   abandon the frame immediately
//  i_rx_mode_done   in   1   1-cycle pulse from RX: the current mode is complete
//  i_rx_pre         in   1   preamble bit value from RX, valid with mode_done in preamble states
//  i_rx_error       in   1   RX check failure, valid with mode_done in PARITY/TOKEN/CRC
//  i_rx_data        in   8   deserialized byte, valid with mode_done in byte states
//  i_fifo_full      in   1   read FIFO full
//  o_rx_en          out  1   RX enable
//  o_rx_mode        out  4   RX mode: PRE=0000 DESER=0011 TOKEN=0101 PARITY=0110 CRC=0111 ERROR=1111
//  o_fifo_wr_en     out  1   1-cycle write strobe
//  o_fifo_wr_data   out  8   byte to FIFO
//  o_words_rcvd     out  W   completed data words in the current/last frame
//  o_busy           out  1   FSM not in IDLE
//  o_done           out  1   1-cycle pulse: frame ended cleanly
//  o_err            out  1   1-cycle pulse: frame ended with an error
//  o_err_code       out  3   0 none, 1 NACK, 2 parity, 3 token, 4 CRC, 5 overrun, 6 FIFO overflow, 7 timeout; held until next start
// BEHAVIOUR
//  Reset: all outputs 0, o_rx_mode=0000, FSM=IDLE, counters 0.
//  Mode handling:
//  - o_rx_en=1 and o_rx_mode are registered and stable in every state except IDLE.
//  - On i_rx_mode_done the FSM moves to the next state; the new mode appears the following cycle.
//  - i_rx_mode_done is ignored in IDLE.
//  States, modes and transitions:
//  - IDLE: on i_rd_start, load the word count, clear o_words_rcvd and o_err_code, go to ACK. rx_en rises 1 cycle after start.
//  - ACK (PRE): pre=0 -> BYTE_HI; pre=1 -> RECOVER, code 1.
//  - BYTE_HI / BYTE_LO (DESER): at done, write i_rx_data to the FIFO (wr_en in the next cycle, MSB byte first).
//    If i_fifo_full at done -> RECOVER, code 6, no write. Otherwise BYTE_HI->BYTE_LO, BYTE_LO->PARITY.
//  - PARITY: err -> RECOVER, code 2. Otherwise increment words_rcvd, go to PRE_NEXT.
//  - PRE_NEXT (PRE): pre=1 = another data word.
//    - remaining>0 -> BYTE_HI.
//    - remaining==0 -> RECOVER, code 5.
//    pre=0 -> CRC_PRE2. Early end (words_rcvd < requested) is legal, not an error.
//  - CRC_PRE2 (PRE): pre=1 -> TOKEN; pre=0 -> RECOVER, code 3.
//  - TOKEN: err -> RECOVER, code 3. Otherwise -> CRC.
//  - CRC: err -> RECOVER, code 4. Otherwise o_done pulse, -> IDLE.
//  - RECOVER (ERROR mode): wait for mode_done, then o_err pulse, -> IDLE.
//  Boundaries and priorities:
//  - i_rd_word_cnt=0 is treated as 1.
//  - i_rd_start while busy is ignored.
//  - i_abort has priority over everything: next cycle IDLE, rx_en=0, no done/err pulse, and no FIFO write even if mode_done coincides.
//  - i_rd_start in the same cycle as the done/err pulse is ignored: the FSM is not yet in IDLE.
//  - Asynchronous reset mid-frame returns to reset values immediately.
// CONFIGURATION
//  DDR_RX_TIMEOUT_EN defined:
//  - A per-mode cycle counter clears on every state change.
//  - Reaching TIMEOUT_CYCLES in any state except IDLE/RECOVER -> RECOVER, code 7.
//  - In RECOVER the timeout forces IDLE plus an o_err pulse.
//  DDR_RX_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely and code 7 never occurs.
// STRUCTURE
//  ddr_rx_pkg: RX mode localparams, state enum, err_code constants; shared with the RX and CCC engine.
//  Sub-module ddr_rx_watchdog (counter + compare), instantiated only under DDR_RX_TIMEOUT_EN.
// TESTING
//  1. cnt=2, ACK pre=0, bytes A1,D4 / 3C,5A, parity ok, pre=1, pre=0, pre=1, token ok, CRC ok
//     -> FIFO gets A1,D4,3C,5A; words_rcvd=2; o_done.
//  2. ACK pre=1 -> mode 1111; after mode_done, o_err with code 1; FIFO untouched.
//  3. cnt=3, target ends after word 1 (pre=0 then 1) -> o_done, words_rcvd=1, code 0.
//  4. Parity err on word 1 -> mode 1111, o_err code 2. Next start is accepted and completes cleanly.
//  5. cnt=1, pre=1 after word 1 -> code 5. i_fifo_full at BYTE_LO done -> code 6, only 1 byte written.
//  6. i_abort coinciding with mode_done in BYTE_HI -> no write, IDLE next cycle.
//     With DDR_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no mode_done -> code 7.

Source files
------------

// File: rtl/ddr_rx_pkg.sv
// Shared definitions for the HDR-DDR RX path: RX mode encodings, the frame
// sequencer state enum and the error codes reported to the DDR CCC engine.
package ddr_rx_pkg;

    // Mode encodings understood by the RX deserializer.
    localparam logic [3:0] RX_MODE_PRE    = 4'b0000;
    localparam logic [3:0] RX_MODE_DESER  = 4'b0011;
    localparam logic [3:0] RX_MODE_TOKEN  = 4'b0101;
    localparam logic [3:0] RX_MODE_PARITY = 4'b0110;
    localparam logic [3:0] RX_MODE_CRC    = 4'b0111;
    localparam logic [3:0] RX_MODE_ERROR  = 4'b1111;

    // Frame sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACK,
        ST_BYTE_HI,
        ST_BYTE_LO,
        ST_PARITY,
        ST_PRE_NEXT,
        ST_CRC_PRE2,
        ST_TOKEN,
        ST_CRC,
        ST_RECOVER
    } rx_state_t;

    // Error codes, held on o_err_code until the next accepted start.
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_NACK     = 3'd1;
    localparam logic [2:0] ERR_PARITY   = 3'd2;
    localparam logic [2:0] ERR_TOKEN    = 3'd3;
    localparam logic [2:0] ERR_CRC      = 3'd4;
    localparam logic [2:0] ERR_OVERRUN  = 3'd5;
    localparam logic [2:0] ERR_FIFO_OVF = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd7;

endpackage

// File: rtl/ddr_rx_watchdog.sv
// Per-state cycle watchdog for the RX frame sequencer. The count restarts
// whenever the observed state changes; o_expired flags the TIMEOUT_CYCLES-th
// cycle spent in one non-IDLE state. Built only when DDR_RX_TIMEOUT_EN is
// defined.
`ifdef DDR_RX_TIMEOUT_EN
module ddr_rx_watchdog
    import ddr_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      i_sys_clk,
    input  logic      i_sys_rst,
    input  rx_state_t i_state,
    output logic      o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_reg;
    rx_state_t     prev_state_reg;

    // Count completed cycles in the current state; a state change restarts it.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            cnt_reg        <= '0;
            prev_state_reg <= ST_IDLE;
        end else begin
            prev_state_reg <= i_state;
            if (i_state == ST_IDLE) begin
                cnt_reg <= '0;
            end else if (i_state != prev_state_reg) begin
                cnt_reg <= CW'(1);
            end else if (!o_expired) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    // The first cycle of a new state counts as zero completed cycles.
    assign o_expired = (i_state == prev_state_reg) && (i_state != ST_IDLE) &&
                       (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/ddr_rx_frame_ctrl.sv
// HDR-DDR RX frame sequencer for controller reads. Steps the deserializer
// through ACK, data words (two bytes plus parity), CRC preamble, token and
// CRC, pushes received bytes to the read FIFO and reports done/error.
// Optional feature macro: DDR_RX_TIMEOUT_EN adds a per-state timeout
// (error code 7) through ddr_rx_watchdog.
module ddr_rx_frame_ctrl
    import ddr_rx_pkg::*;
#(
    parameter int MAX_WORDS      = 255,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int W             = $clog2(MAX_WORDS + 1)
) (
    input  logic         i_sys_clk,
    input  logic         i_sys_rst,
    input  logic         i_rd_start,
    input  logic [W-1:0] i_rd_word_cnt,
    input  logic         i_abort,
    input  logic         i_rx_mode_done,
    input  logic         i_rx_pre,
    input  logic         i_rx_error,
    input  logic [7:0]   i_rx_data,
    input  logic         i_fifo_full,
    output logic         o_rx_en,
    output logic [3:0]   o_rx_mode,
    output logic         o_fifo_wr_en,
    output logic [7:0]   o_fifo_wr_data,
    output logic [W-1:0] o_words_rcvd,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [2:0]   o_err_code
);

    rx_state_t    state_reg;
    logic [W-1:0] word_cnt_reg;
    logic         timeout_hit;

`ifdef DDR_RX_TIMEOUT_EN
    ddr_rx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_sys_clk(i_sys_clk),
        .i_sys_rst(i_sys_rst),
        .i_state  (state_reg),
        .o_expired(timeout_hit)
    );
`else
    // No watchdog: the sequencer waits indefinitely. TIMEOUT_CYCLES stays
    // referenced so both builds share one parameter list.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    assign o_busy = (state_reg != ST_IDLE);

    // Frame sequencer: state, RX mode, FIFO strobe and status, all registered.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_reg      <= ST_IDLE;
            word_cnt_reg   <= '0;
            o_rx_en        <= 1'b0;
            o_rx_mode      <= RX_MODE_PRE;
            o_fifo_wr_en   <= 1'b0;
            o_fifo_wr_data <= '0;
            o_words_rcvd   <= '0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_err_code     <= ERR_NONE;
        end else begin
            o_fifo_wr_en <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            if (i_abort) begin
                // Silent abandon: no pulse, no write, even with a coinciding mode_done.
                state_reg <= ST_IDLE;
                o_rx_en   <= 1'b0;
                o_rx_mode <= RX_MODE_PRE;
            end else if (timeout_hit && state_reg == ST_RECOVER) begin
                state_reg <= ST_IDLE;
                o_rx_en   <= 1'b0;
                o_rx_mode <= RX_MODE_PRE;
                o_err     <= 1'b1;
            end else if (timeout_hit && state_reg != ST_IDLE) begin
                state_reg  <= ST_RECOVER;
                o_rx_mode  <= RX_MODE_ERROR;
                o_err_code <= ERR_TIMEOUT;
            end else if (state_reg == ST_IDLE) begin
                // A start during the done/err pulse cycle still belongs to the old frame.
                if (i_rd_start && !o_done && !o_err) begin
                    word_cnt_reg <= (i_rd_word_cnt == '0) ? W'(1) : i_rd_word_cnt;
                    o_words_rcvd <= '0;
                    o_err_code   <= ERR_NONE;
                    state_reg    <= ST_ACK;
                    o_rx_en      <= 1'b1;
                    o_rx_mode    <= RX_MODE_PRE;
                end
            end else if (i_rx_mode_done) begin
                case (state_reg)
                    ST_ACK: begin
                        if (i_rx_pre) begin
                            state_reg  <= ST_RECOVER;
                            o_rx_mode  <= RX_MODE_ERROR;
                            o_err_code <= ERR_NACK;
                        end else begin
                            state_reg <= ST_BYTE_HI;
                            o_rx_mode <= RX_MODE_DESER;
                        end
                    end
                    ST_BYTE_HI, ST_BYTE_LO: begin
                        if (i_fifo_full) begin
                            state_reg  <= ST_RECOVER;
                            o_rx_mode  <= RX_MODE_ERROR;
                            o_err_code <= ERR_FIFO_OVF;
                        end else begin
                            o_fifo_wr_en   <= 1'b1;
                            o_fifo_wr_data <= i_rx_data;
                            if (state_reg == ST_BYTE_HI) begin
                                state_reg <= ST_BYTE_LO;
                                o_rx_mode <= RX_MODE_DESER;
                            end else begin
                                state_reg <= ST_PARITY;
                                o_rx_mode <= RX_MODE_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (i_rx_error) begin
                            state_reg  <= ST_RECOVER;
                            o_rx_mode  <= RX_MODE_ERROR;
                            o_err_code <= ERR_PARITY;
                        end else begin
                            o_words_rcvd <= o_words_rcvd + W'(1);
                            state_reg    <= ST_PRE_NEXT;
                            o_rx_mode    <= RX_MODE_PRE;
                        end
                    end
                    ST_PRE_NEXT: begin
                        if (!i_rx_pre) begin
                            // Target ended the data phase; early end is legal.
                            state_reg <= ST_CRC_PRE2;
                            o_rx_mode <= RX_MODE_PRE;
                        end else if (o_words_rcvd < word_cnt_reg) begin
                            state_reg <= ST_BYTE_HI;
                            o_rx_mode <= RX_MODE_DESER;
                        end else begin
                            state_reg  <= ST_RECOVER;
                            o_rx_mode  <= RX_MODE_ERROR;
                            o_err_code <= ERR_OVERRUN;
                        end
                    end
                    ST_CRC_PRE2: begin
                        if (i_rx_pre) begin
                            state_reg <= ST_TOKEN;
                            o_rx_mode <= RX_MODE_TOKEN;
                        end else begin
                            state_reg  <= ST_RECOVER;
                            o_rx_mode  <= RX_MODE_ERROR;
                            o_err_code <= ERR_TOKEN;
                        end
                    end
                    ST_TOKEN: begin
                        if (i_rx_error) begin
                            state_reg  <= ST_RECOVER;
                            o_rx_mode  <= RX_MODE_ERROR;
                            o_err_code <= ERR_TOKEN;
                        end else begin
                            state_reg <= ST_CRC;
                            o_rx_mode <= RX_MODE_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (i_rx_error) begin
                            state_reg  <= ST_RECOVER;
                            o_rx_mode  <= RX_MODE_ERROR;
                            o_err_code <= ERR_CRC;
                        end else begin
                            state_reg <= ST_IDLE;
                            o_rx_en   <= 1'b0;
                            o_rx_mode <= RX_MODE_PRE;
                            o_done    <= 1'b1;
                        end
                    end
                    ST_RECOVER: begin
                        state_reg <= ST_IDLE;
                        o_rx_en   <= 1'b0;
                        o_rx_mode <= RX_MODE_PRE;
                        o_err     <= 1'b1;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        o_rx_en   <= 1'b0;
                        o_rx_mode <= RX_MODE_PRE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr_rx_frame_ctrl.sv
// Directed self-checking bench for ddr_rx_frame_ctrl. Inputs change 1 time
// unit after the rising edge; outputs are checked at that same point, i.e.
// after the registered outputs of the edge have settled.
module tb_ddr_rx_frame_ctrl;

    logic       i_sys_clk_tb = 1'b0;
    logic       i_sys_rst_tb;
    logic       rd_start_tb;
    logic [7:0] rd_word_cnt_tb;
    logic       abort_tb;
    logic       rx_mode_done_tb;
    logic       rx_pre_tb;
    logic       rx_error_tb;
    logic [7:0] rx_data_tb;
    logic       fifo_full_tb;
    logic       rx_en_tb;
    logic [3:0] rx_mode_tb;
    logic       fifo_wr_en_tb;
    logic [7:0] fifo_wr_data_tb;
    logic [7:0] words_rcvd_tb;
    logic       busy_tb;
    logic       done_tb;
    logic       err_tb;
    logic [2:0] err_code_tb;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    int err_seen  = 0;
    logic [7:0] fifo_q[$];

    always #10 i_sys_clk_tb = ~i_sys_clk_tb;

    ddr_rx_frame_ctrl #(
        .MAX_WORDS     (255),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_sys_clk     (i_sys_clk_tb),
        .i_sys_rst     (i_sys_rst_tb),
        .i_rd_start    (rd_start_tb),
        .i_rd_word_cnt (rd_word_cnt_tb),
        .i_abort       (abort_tb),
        .i_rx_mode_done(rx_mode_done_tb),
        .i_rx_pre      (rx_pre_tb),
        .i_rx_error    (rx_error_tb),
        .i_rx_data     (rx_data_tb),
        .i_fifo_full   (fifo_full_tb),
        .o_rx_en       (rx_en_tb),
        .o_rx_mode     (rx_mode_tb),
        .o_fifo_wr_en  (fifo_wr_en_tb),
        .o_fifo_wr_data(fifo_wr_data_tb),
        .o_words_rcvd  (words_rcvd_tb),
        .o_busy        (busy_tb),
        .o_done        (done_tb),
        .o_err         (err_tb),
        .o_err_code    (err_code_tb)
    );

    // Read-FIFO model and pulse counters, sampled mid-cycle.
    always @(negedge i_sys_clk_tb) begin
        if (fifo_wr_en_tb) fifo_q.push_back(fifo_wr_data_tb);
        if (done_tb) done_seen++;
        if (err_tb) err_seen++;
    end

    task automatic tick();
        @(posedge i_sys_clk_tb);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] cnt);
        rd_start_tb    = 1'b1;
        rd_word_cnt_tb = cnt;
        tick();
        rd_start_tb    = 1'b0;
    endtask

    // One RX mode completion with the given companion values.
    task automatic rx_step(input logic pre, input logic err, input logic [7:0] data, input logic full);
        rx_pre_tb       = pre;
        rx_error_tb     = err;
        rx_data_tb      = data;
        fifo_full_tb    = full;
        rx_mode_done_tb = 1'b1;
        tick();
        rx_mode_done_tb = 1'b0;
        rx_pre_tb       = 1'b0;
        rx_error_tb     = 1'b0;
        fifo_full_tb    = 1'b0;
    endtask

    // Two bytes followed by a clean parity.
    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo);
        rx_step(1'b0, 1'b0, hi, 1'b0);
        rx_step(1'b0, 1'b0, lo, 1'b0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        i_sys_rst_tb = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rx_en_tb, busy_tb, fifo_wr_en_tb, done_tb, err_tb} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000", {rx_en_tb, busy_tb, fifo_wr_en_tb, done_tb, err_tb});
        end
        checks++;
        if ({rx_mode_tb, words_rcvd_tb, err_code_tb} !== 15'h0) begin
            failures++;
            $display("FAIL reset_values: mode=%b words=%0d code=%0d want all 0", rx_mode_tb, words_rcvd_tb, err_code_tb);
        end
        i_sys_rst_tb = 1'b0;
        tick();
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({busy_tb, rx_en_tb} !== 2'b00) begin
            failures++;
            $display("FAIL idle_ignores_mode_done: busy/rx_en=%b want 00", {busy_tb, rx_en_tb});
        end
        $display("test_reset: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_full_frame();
        logic [7:0] exp_bytes[4];
        exp_bytes = '{8'hA1, 8'hD4, 8'h3C, 8'h5A};
        tick();
        fifo_q.delete();
        start_frame(8'd2);
        checks++;
        if ({rx_en_tb, busy_tb, rx_mode_tb} !== 6'b110000) begin
            failures++;
            $display("FAIL full_start: en/busy/mode=%b want 110000", {rx_en_tb, busy_tb, rx_mode_tb});
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_mode_tb !== 4'b0011) begin
            failures++;
            $display("FAIL full_ack_to_deser: mode=%b want 0011", rx_mode_tb);
        end
        rx_step(1'b0, 1'b0, 8'hA1, 1'b0);
        checks++;
        if ({fifo_wr_en_tb, fifo_wr_data_tb} !== 9'h1A1) begin
            failures++;
            $display("FAIL full_wr_strobe: wr_en=%b data=%h want 1 a1", fifo_wr_en_tb, fifo_wr_data_tb);
        end
        rx_step(1'b0, 1'b0, 8'hD4, 1'b0);
        checks++;
        if (rx_mode_tb !== 4'b0110) begin
            failures++;
            $display("FAIL full_parity_mode: mode=%b want 0110", rx_mode_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({words_rcvd_tb, rx_mode_tb} !== {8'd1, 4'b0000}) begin
            failures++;
            $display("FAIL full_word1: words=%0d mode=%b want 1 0000", words_rcvd_tb, rx_mode_tb);
        end
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        send_word(8'h3C, 8'h5A);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_mode_tb !== 4'b0101) begin
            failures++;
            $display("FAIL full_token_mode: mode=%b want 0101", rx_mode_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_mode_tb !== 4'b0111) begin
            failures++;
            $display("FAIL full_crc_mode: mode=%b want 0111", rx_mode_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({done_tb, err_tb, busy_tb, rx_en_tb} !== 4'b1000) begin
            failures++;
            $display("FAIL full_done: done/err/busy/en=%b want 1000", {done_tb, err_tb, busy_tb, rx_en_tb});
        end
        tick();
        checks++;
        if (done_tb !== 1'b0) begin
            failures++;
            $display("FAIL full_done_pulse_width: done=%b want 0", done_tb);
        end
        checks++;
        if (fifo_q.size() != 4 || fifo_q[0] !== exp_bytes[0] || fifo_q[1] !== exp_bytes[1] ||
            fifo_q[2] !== exp_bytes[2] || fifo_q[3] !== exp_bytes[3]) begin
            failures++;
            $display("FAIL full_fifo_bytes: got %p want a1 d4 3c 5a", fifo_q);
        end
        checks++;
        if ({words_rcvd_tb, err_code_tb} !== {8'd2, 3'd0}) begin
            failures++;
            $display("FAIL full_status: words=%0d code=%0d want 2 0", words_rcvd_tb, err_code_tb);
        end
        $display("test_full_frame: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_nack();
        tick();
        fifo_q.delete();
        start_frame(8'd1);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({rx_mode_tb, err_tb} !== 5'b11110) begin
            failures++;
            $display("FAIL nack_recover: mode=%b err=%b want 1111 0", rx_mode_tb, err_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({err_tb, done_tb, busy_tb, err_code_tb} !== {3'b100, 3'd1}) begin
            failures++;
            $display("FAIL nack_err: err/done/busy=%b code=%0d want 100 1", {err_tb, done_tb, busy_tb}, err_code_tb);
        end
        tick();
        checks++;
        if (fifo_q.size() != 0) begin
            failures++;
            $display("FAIL nack_fifo: size=%0d want 0", fifo_q.size());
        end
        $display("test_nack: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_early_end();
        tick();
        fifo_q.delete();
        start_frame(8'd3);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'h11, 8'h22);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({done_tb, err_tb, words_rcvd_tb, err_code_tb} !== {2'b10, 8'd1, 3'd0}) begin
            failures++;
            $display("FAIL early_end: done=%b err=%b words=%0d code=%0d want 1 0 1 0", done_tb, err_tb, words_rcvd_tb, err_code_tb);
        end
        checks++;
        if (fifo_q.size() != 2) begin
            failures++;
            $display("FAIL early_end_fifo: size=%0d want 2", fifo_q.size());
        end
        $display("test_early_end: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_parity_err();
        tick();
        start_frame(8'd2);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h12, 1'b0);
        rx_step(1'b0, 1'b0, 8'h34, 1'b0);
        rx_step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({rx_mode_tb, words_rcvd_tb} !== {4'b1111, 8'd0}) begin
            failures++;
            $display("FAIL parity_recover: mode=%b words=%0d want 1111 0", rx_mode_tb, words_rcvd_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({err_tb, err_code_tb} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL parity_err: err=%b code=%0d want 1 2", err_tb, err_code_tb);
        end
        tick();
        start_frame(8'd1);
        checks++;
        if ({busy_tb, err_code_tb} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL parity_restart: busy=%b code=%0d want 1 0", busy_tb, err_code_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'h55, 8'hAA);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({done_tb, err_tb, words_rcvd_tb, err_code_tb} !== {2'b10, 8'd1, 3'd0}) begin
            failures++;
            $display("FAIL parity_next_clean: done=%b err=%b words=%0d code=%0d want 1 0 1 0", done_tb, err_tb, words_rcvd_tb, err_code_tb);
        end
        $display("test_parity_err: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_overrun_and_fifo_full();
        tick();
        start_frame(8'd1);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'h01, 8'h02);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_mode_tb !== 4'b1111) begin
            failures++;
            $display("FAIL overrun_recover: mode=%b want 1111", rx_mode_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({err_tb, err_code_tb} !== {1'b1, 3'd5}) begin
            failures++;
            $display("FAIL overrun_err: err=%b code=%0d want 1 5", err_tb, err_code_tb);
        end
        tick();
        fifo_q.delete();
        start_frame(8'd1);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h77, 1'b0);
        rx_step(1'b0, 1'b0, 8'h88, 1'b1);
        checks++;
        if ({rx_mode_tb, fifo_wr_en_tb} !== 5'b11110) begin
            failures++;
            $display("FAIL fifo_full_recover: mode=%b wr_en=%b want 1111 0", rx_mode_tb, fifo_wr_en_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({err_tb, err_code_tb} !== {1'b1, 3'd6}) begin
            failures++;
            $display("FAIL fifo_full_err: err=%b code=%0d want 1 6", err_tb, err_code_tb);
        end
        checks++;
        if (fifo_q.size() != 1 || fifo_q[0] !== 8'h77) begin
            failures++;
            $display("FAIL fifo_full_bytes: got %p want 77", fifo_q);
        end
        $display("test_overrun_and_fifo_full: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_abort();
        int done_base;
        int err_base;
        tick();
        fifo_q.delete();
        done_base = done_seen;
        err_base  = err_seen;
        start_frame(8'd2);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        abort_tb = 1'b1;
        rx_step(1'b0, 1'b0, 8'h99, 1'b0);
        abort_tb = 1'b0;
        checks++;
        if ({busy_tb, rx_en_tb, fifo_wr_en_tb, rx_mode_tb} !== 7'b0) begin
            failures++;
            $display("FAIL abort_idle: busy/en/wr=%b mode=%b want 000 0000", {busy_tb, rx_en_tb, fifo_wr_en_tb}, rx_mode_tb);
        end
        repeat (2) tick();
        checks++;
        if (fifo_q.size() != 0 || done_seen != done_base || err_seen != err_base) begin
            failures++;
            $display("FAIL abort_silent: fifo=%0d done+%0d err+%0d want 0 0 0", fifo_q.size(), done_seen - done_base, err_seen - err_base);
        end
        $display("test_abort: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_boundaries();
        // Word count 0 behaves as 1: a second data preamble is an overrun.
        tick();
        start_frame(8'd0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'hE0, 8'hE1);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({err_tb, err_code_tb} !== {1'b1, 3'd5}) begin
            failures++;
            $display("FAIL cnt0_as_1: err=%b code=%0d want 1 5", err_tb, err_code_tb);
        end
        // Start while busy must not reload the count or clear words_rcvd.
        tick();
        start_frame(8'd2);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'hF0, 8'hF1);
        start_frame(8'd5);
        checks++;
        if ({busy_tb, words_rcvd_tb, rx_mode_tb} !== {1'b1, 8'd1, 4'b0000}) begin
            failures++;
            $display("FAIL busy_start_ignored: busy=%b words=%0d mode=%b want 1 1 0000", busy_tb, words_rcvd_tb, rx_mode_tb);
        end
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        send_word(8'hF2, 8'hF3);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_mode_tb !== 4'b1111) begin
            failures++;
            $display("FAIL busy_start_count_kept: mode=%b want 1111", rx_mode_tb);
        end
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        // Start held across the final mode_done and the done pulse is ignored.
        tick();
        start_frame(8'd1);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'h10, 8'h20);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rx_step(1'b1, 1'b0, 8'h00, 1'b0);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        rd_start_tb    = 1'b1;
        rd_word_cnt_tb = 8'd1;
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (done_tb !== 1'b1) begin
            failures++;
            $display("FAIL start_with_done_pulse: done=%b want 1", done_tb);
        end
        tick();
        rd_start_tb = 1'b0;
        checks++;
        if ({busy_tb, rx_en_tb} !== 2'b00) begin
            failures++;
            $display("FAIL start_with_done_ignored: busy/en=%b want 00", {busy_tb, rx_en_tb});
        end
        $display("test_boundaries: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_async_reset();
        tick();
        start_frame(8'd2);
        rx_step(1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'h42, 8'h43);
        #3;
        i_sys_rst_tb = 1'b1;
        #1;
        checks++;
        if ({busy_tb, rx_en_tb, rx_mode_tb, words_rcvd_tb} !== 14'h0) begin
            failures++;
            $display("FAIL async_reset: busy=%b en=%b mode=%b words=%0d want 0 0 0000 0", busy_tb, rx_en_tb, rx_mode_tb, words_rcvd_tb);
        end
        tick();
        i_sys_rst_tb = 1'b0;
        tick();
        start_frame(8'd1);
        checks++;
        if ({busy_tb, rx_en_tb} !== 2'b11) begin
            failures++;
            $display("FAIL async_reset_restart: busy/en=%b want 11", {busy_tb, rx_en_tb});
        end
        abort_tb = 1'b1;
        tick();
        abort_tb = 1'b0;
        $display("test_async_reset: checks=%0d failures=%0d", checks, failures);
    endtask

`ifdef DDR_RX_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        tick();
        start_frame(8'd1);
        waited = 0;
        while (err_tb !== 1'b1 && waited < 80) begin
            tick();
            waited++;
        end
        checks++;
        if ({err_tb, err_code_tb} !== {1'b1, 3'd7}) begin
            failures++;
            $display("FAIL timeout_err: err=%b code=%0d after %0d cycles want 1 7", err_tb, err_code_tb, waited);
        end
        $display("test_timeout: checks=%0d failures=%0d", checks, failures);
    endtask
`endif

    initial begin
        i_sys_rst_tb    = 1'b1;
        rd_start_tb     = 1'b0;
        rd_word_cnt_tb  = 8'd0;
        abort_tb        = 1'b0;
        rx_mode_done_tb = 1'b0;
        rx_pre_tb       = 1'b0;
        rx_error_tb     = 1'b0;
        rx_data_tb      = 8'h00;
        fifo_full_tb    = 1'b0;
        test_reset();
        test_full_frame();
        test_nack();
        test_early_end();
        test_parity_err();
        test_overrun_and_fifo_full();
        test_abort();
        test_boundaries();
        test_async_reset();
`ifdef DDR_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
